// File: rtl/alu_pkg.sv
// alu_pkg: shared op encoding and helper functions for the EX-stage ALU.
package alu_pkg;

   localparam int unsigned ALU_WIDTH = 32;

   // 2-bit operation select as driven by the decode stage
   typedef logic [1:0] alu_op_t;

   localparam alu_op_t ALU_ADD = 2'b00;
   localparam alu_op_t ALU_SUB = 2'b01;
   localparam alu_op_t ALU_AND = 2'b10;
   localparam alu_op_t ALU_OR  = 2'b11;

   // Two's-complement overflow of an addition, judged from the sign bits of
   // both addends and the sum: same-sign addends producing a different-sign sum.
   function automatic logic add_ovf(input logic a_msb,
                                    input logic b_msb,
                                    input logic s_msb);
      return (a_msb == b_msb) && (s_msb != a_msb);
   endfunction

   // True when the operation runs through the adder/subtractor
   function automatic logic is_arith(input alu_op_t op);
      logic arith;
      case (op)
         ALU_ADD: arith = 1'b1;
         ALU_SUB: arith = 1'b1;
         ALU_AND: arith = 1'b0;
         ALU_OR:  arith = 1'b0;
         default: arith = 1'b0;
      endcase
      return arith;
   endfunction

endpackage : alu_pkg

// File: rtl/alu_addsub.sv
// alu_addsub: combinational WIDTH-bit adder/subtractor with signed overflow.
// Subtraction is a + ~b + 1, so one carry chain serves both operations.
module alu_addsub
   import alu_pkg::*;
#(
   parameter int unsigned WIDTH = 32
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             sub,
   output logic [WIDTH-1:0] sum,
   output logic             overflow
);

   logic [WIDTH-1:0] b_eff_s;
   logic [WIDTH-1:0] cin_s;

   // Invert the second operand and inject the +1 carry for subtraction
   always_comb begin
      b_eff_s = b;
      cin_s   = {WIDTH{1'b0}};
      if (sub) begin
         b_eff_s = ~b;
         cin_s   = {{(WIDTH-1){1'b0}}, 1'b1};
      end else begin
         b_eff_s = b;
         cin_s   = {WIDTH{1'b0}};
      end
   end

   // Modulo-2^WIDTH sum; overflow judged against the effective addend, which
   // for SUB reduces to (a_msb != b_msb) && (diff_msb != a_msb)
   always_comb begin
      sum      = a + b_eff_s + cin_s;
      overflow = add_ovf(a[WIDTH-1], b_eff_s[WIDTH-1], sum[WIDTH-1]);
   end

endmodule : alu_addsub

// File: rtl/alu_unit.sv
// alu_unit: 32-bit EX-stage ALU (ADD/SUB/AND/OR) with registered result,
// signed-overflow and zero flags; acts as the EX/MEM boundary for the result.
module alu_unit
   import alu_pkg::*;
#(
   parameter int unsigned WIDTH = ALU_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [1:0]       op,
   input  logic             is_sign,
   output logic [WIDTH-1:0] result,
   output logic             overflow,
   output logic             zero
);

   logic             sub_s;
   logic [WIDTH-1:0] addsub_sum_s;
   logic             addsub_ovf_s;
   logic [WIDTH-1:0] result_s;
   logic             overflow_s;
   logic             zero_s;
   logic [WIDTH-1:0] result_r;
   logic             overflow_r;
   logic             zero_r;

   // Select subtraction in the shared adder only for SUB
   always_comb begin
      if (alu_op_t'(op) == ALU_SUB) begin
         sub_s = 1'b1;
      end else begin
         sub_s = 1'b0;
      end
   end

   alu_addsub #(
      .WIDTH    (WIDTH)
   ) u_addsub (
      .a        (a),
      .b        (b),
      .sub      (sub_s),
      .sum      (addsub_sum_s),
      .overflow (addsub_ovf_s)
   );

   // Next-state result mux; overflow only reported for signed arithmetic
   always_comb begin
      result_s   = {WIDTH{1'b0}};
      overflow_s = 1'b0;
      case (alu_op_t'(op))
         ALU_ADD: begin
            result_s   = addsub_sum_s;
            overflow_s = is_sign & addsub_ovf_s;
         end
         ALU_SUB: begin
            result_s   = addsub_sum_s;
            overflow_s = is_sign & addsub_ovf_s;
         end
         ALU_AND: begin
            result_s   = a & b;
            overflow_s = 1'b0;
         end
         ALU_OR: begin
            result_s   = a | b;
            overflow_s = 1'b0;
         end
         default: begin
            result_s   = {WIDTH{1'b0}};
            overflow_s = 1'b0;
         end
      endcase
   end

   // Zero flag derived from the same next result so it always matches result
   always_comb begin
      if (result_s == {WIDTH{1'b0}}) begin
         zero_s = 1'b1;
      end else begin
         zero_s = 1'b0;
      end
   end

   // Output register; async reset discards any in-flight operation
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         result_r   <= {WIDTH{1'b0}};
         overflow_r <= 1'b0;
         zero_r     <= 1'b1;
      end else begin
         result_r   <= result_s;
         overflow_r <= overflow_s;
         zero_r     <= zero_s;
      end
   end

   assign result   = result_r;
   assign overflow = overflow_r;
   assign zero     = zero_r;

endmodule : alu_unit

// File: tb/tb_alu_unit.sv
// tb_alu_unit: directed corner cases plus randomized stimulus against a
// plain-arithmetic reference model of the ALU.
module tb_alu_unit;
   import alu_pkg::*;

   logic        clk;
   logic        rst;
   logic [31:0] a;
   logic [31:0] b;
   logic [1:0]  op;
   logic        is_sign;
   logic [31:0] result;
   logic        overflow;
   logic        zero;

   int checks_cnt;
   int errors_cnt;

   alu_unit #(.WIDTH(32)) dut (
      .clk      (clk),
      .rst      (rst),
      .a        (a),
      .b        (b),
      .op       (op),
      .is_sign  (is_sign),
      .result   (result),
      .overflow (overflow),
      .zero     (zero)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks_cnt++;
      if (obs !== exp) begin
         errors_cnt++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   // Reference model: integer arithmetic with range checks on true signed values
   function automatic void model(input logic [31:0] ma, input logic [31:0] mb,
                                 input logic [1:0] mop, input logic msign,
                                 output logic [31:0] r, output logic ov, output logic z);
      longint sa;
      longint sb;
      longint exact;
      sa    = longint'($signed(ma));
      sb    = longint'($signed(mb));
      exact = 64'sd0;
      ov    = 1'b0;
      case (mop)
         2'd0: begin r = ma + mb; exact = sa + sb; end
         2'd1: begin r = ma - mb; exact = sa - sb; end
         2'd2: r = ma & mb;
         default: r = ma | mb;
      endcase
      if (msign && mop < 2'd2 && (exact > 64'sd2147483647 || exact < -64'sd2147483648))
         ov = 1'b1;
      z = (r == 32'd0);
   endfunction

   // Apply one op, let one edge pass, then compare all three outputs
   task automatic apply(input string tag, input logic [31:0] ta, input logic [31:0] tb,
                        input logic [1:0] top, input logic ts);
      logic [31:0] er;
      logic        eo;
      logic        ez;
      @(negedge clk);
      a = ta; b = tb; op = top; is_sign = ts;
      model(ta, tb, top, ts, er, eo, ez);
      @(posedge clk);
      #1;
      check_val({tag, ".result"}, result, er);
      check_val({tag, ".overflow"}, {31'd0, overflow}, {31'd0, eo});
      check_val({tag, ".zero"}, {31'd0, zero}, {31'd0, ez});
   endtask

   initial begin
      checks_cnt = 0;
      errors_cnt = 0;
      rst = 1'b0;
      a = $urandom; b = $urandom; op = 2'($urandom_range(3)); is_sign = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check_val("reset.result", result, 32'h0000_0000);
      check_val("reset.overflow", {31'd0, overflow}, 32'd0);
      check_val("reset.zero", {31'd0, zero}, 32'd1);

      @(negedge clk);
      rst = 1'b1;
      apply("post_reset_add", 32'd1, 32'd2, ALU_ADD, 1'b1);
      check_val("post_reset_add.value", result, 32'd3);

      // Op sweep
      apply("sweep_add", 32'd1, 32'd2, ALU_ADD, 1'b1);
      apply("sweep_sub", 32'd1, 32'd2, ALU_SUB, 1'b1);
      check_val("sweep_sub.value", result, 32'hFFFF_FFFF);
      apply("sweep_and", 32'd1, 32'd2, ALU_AND, 1'b1);
      check_val("sweep_and.zero", {31'd0, zero}, 32'd1);
      apply("sweep_or", 32'd1, 32'd2, ALU_OR, 1'b1);

      // Overflow corners
      apply("add_ovf_s", 32'h7FFF_FFFF, 32'd1, ALU_ADD, 1'b1);
      check_val("add_ovf_s.flag", {31'd0, overflow}, 32'd1);
      apply("add_ovf_u", 32'h7FFF_FFFF, 32'd1, ALU_ADD, 1'b0);
      check_val("add_ovf_u.value", result, 32'h8000_0000);
      apply("sub_ovf_s", 32'h8000_0000, 32'd1, ALU_SUB, 1'b1);
      check_val("sub_ovf_s.value", result, 32'h7FFF_FFFF);
      check_val("sub_ovf_s.flag", {31'd0, overflow}, 32'd1);
      apply("sub_eq", 32'd5, 32'd5, ALU_SUB, 1'b1);
      apply("wrap_u", 32'hFFFF_FFFF, 32'd1, ALU_ADD, 1'b0);
      check_val("wrap_u.zero", {31'd0, zero}, 32'd1);
      apply("wrap_s", 32'hFFFF_FFFF, 32'd1, ALU_ADD, 1'b1);
      apply("neg_add_ovf", 32'h8000_0000, 32'h8000_0000, ALU_ADD, 1'b1);
      apply("logic_no_ovf", 32'h7FFF_FFFF, 32'h7FFF_FFFF, ALU_OR, 1'b1);

      // Async reset between edges while outputs hold 3
      apply("pre_async", 32'd1, 32'd2, ALU_ADD, 1'b1);
      #2;
      rst = 1'b0;
      #1;
      check_val("async.result", result, 32'd0);
      check_val("async.overflow", {31'd0, overflow}, 32'd0);
      check_val("async.zero", {31'd0, zero}, 32'd1);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
      check_val("async_resume.result", result, 32'd3);
      check_val("async_resume.zero", {31'd0, zero}, 32'd0);

      // Randomized stimulus with biased corner operands
      for (int i = 0; i < 300; i++) begin
         logic [31:0] ra;
         logic [31:0] rb;
         ra = $urandom;
         rb = $urandom;
         case ($urandom_range(5))
            0: ra = 32'h7FFF_FFFF;
            1: ra = 32'h8000_0000;
            2: rb = ra;
            3: rb = 32'hFFFF_FFFF;
            default: ;
         endcase
         apply("random", ra, rb, 2'($urandom_range(3)), 1'($urandom_range(1)));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks_cnt, errors_cnt);
      $finish;
   end

endmodule : tb_alu_unit

// File: doc/alu_unit.md
Name: alu_unit

Overview:
- 32-bit integer ALU for the MIPS pipeline EX stage.
- Performs ADD, SUB, AND and OR on two 32-bit operands.
- Flags signed overflow and a zero result.
- Outputs are registered: one clock of latency, so the block acts as the EX/MEM boundary for the ALU result.

Parameters:
- WIDTH, 32, operand and result width in bits. Only 32 is required to be supported.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous reset, active-low (0 = reset)
- a  input  WIDTH  first operand (rs)
- b  input  WIDTH  second operand (rt or immediate)
- op  input  2  operation select
- is_sign  input  1  1 = signed instruction (add/sub with overflow detection), 0 = unsigned (addu/subu style)
- result  output  WIDTH  registered operation result
- overflow  output  1  registered signed-overflow flag
- zero  output  1  registered flag, 1 when result is all zeros

Behaviour:
- Reset (rst low, asynchronous): result = 0, overflow = 0, zero = 1. All outputs hold these values while rst is low.
- Reset release: outputs update on the first rising clk edge after rst goes high.
- Op encoding:
  - 2'b00 ADD: a + b
  - 2'b01 SUB: a - b, computed as a + ~b + 1
  - 2'b10 AND: a & b
  - 2'b11 OR: a | b
- Timing: combinational compute from a, b, op and is_sign. All three outputs are captured at each rising clk edge, so latency is exactly 1 cycle.
- There is no enable. A new operation is accepted every cycle and outputs follow the inputs with one cycle of delay.
- Arithmetic is modulo 2^WIDTH. The result is the wrapped value and is always written, even when overflow is flagged. Any trap or writeback suppression is handled by the pipeline, not this block.
- Overflow, signed (is_sign = 1):
  - ADD: overflow = (a[31] == b[31]) and (sum[31] != a[31]).
  - SUB: overflow = (a[31] != b[31]) and (diff[31] != a[31]).
- Overflow, unsigned (is_sign = 0): overflow = 0 for every op. Carry and borrow are not reported.
- Logical ops (AND, OR): overflow = 0 regardless of is_sign.
- zero = (next result == 0), registered in the same cycle as result. It is therefore always consistent with the visible result, including wrapped arithmetic results (e.g. 0xFFFFFFFF + 1 gives zero = 1).
- Reset asserted mid-operation: outputs go to reset values immediately (no clock needed). The in-flight operation is discarded.
- Inputs are never latched separately. Only the computed outputs are registered.

Decomposition:
- Shared package alu_pkg:
  - ALU_ADD = 2'b00, ALU_SUB = 2'b01, ALU_AND = 2'b10, ALU_OR = 2'b11
  - a typedef for the 2-bit op
- One sub-module, alu_addsub: combinational WIDTH-bit adder/subtractor.
  - Inputs: a, b, sub.
  - Outputs: sum, signed overflow.
- alu_unit instantiates alu_addsub, muxes the logical results and registers the outputs.

Test Plan:
- Reset: hold rst = 0 with arbitrary inputs -> result = 0, overflow = 0, zero = 1. Release rst and apply a = 1, b = 2, ADD -> result = 3 one cycle later.
- Op sweep with a = 0x00000001, b = 0x00000002, is_sign = 1, op cycling 0..3 each clock; each result appears one cycle after its op:
  - ADD -> 0x00000003, zero = 0
  - SUB -> 0xFFFFFFFF, overflow = 0
  - AND -> 0x00000000, zero = 1
  - OR -> 0x00000003
- Signed overflow:
  - a = 0x7FFFFFFF, b = 1, ADD, is_sign = 1 -> result = 0x80000000, overflow = 1.
  - Same inputs with is_sign = 0 -> same result, overflow = 0.
- Subtract overflow: a = 0x80000000, b = 1, SUB, is_sign = 1 -> result = 0x7FFFFFFF, overflow = 1. Same with a = 5, b = 5 -> result = 0, zero = 1, overflow = 0.
- Wrap to zero: a = 0xFFFFFFFF, b = 1, ADD, is_sign = 0 -> result = 0, zero = 1, overflow = 0. With is_sign = 1 -> overflow = 0 (-1 + 1).
- Async reset mid-stream: pulse rst low between clock edges while outputs hold 3 -> outputs go to 0/0/1 before the next edge and resume correctly after release.
